ped_request_latch: RTL and testbench



---
 rtl/tlc_pkg.sv | 12 +
 rtl/ped_request_latch_if.sv | 11 +
 rtl/blink_div.sv | 32 +++
 rtl/ped_request_latch.sv | 68 ++++++
 tb/tb_ped_request_latch.sv | 129 ++++++++++++
 5 files changed

// File: rtl/tlc_pkg.sv
// tlc_pkg: shared FSM encodings and lockout counter sizing for the pedestrian request path
package tlc_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    LOCK    = 2'b10
  } state_t;
  localparam int LOCKOUT_CYC_DEF = 16;
  function automatic int lock_w(input int cyc);
    return $clog2(cyc + 1);
  endfunction
endpackage

// File: rtl/ped_request_latch_if.sv
// ped_request_latch_if: press/grant inputs and request/status outputs of the request latch
interface ped_request_latch_if #(parameter int CNT_W = 8);
  logic             btn_pulse;
  logic             grant;
  logic             req;
  logic             req_led;
  logic             lockout;
  logic [CNT_W-1:0] press_cnt;
  modport master (output btn_pulse, grant, input req, req_led, lockout, press_cnt);
  modport slave  (input btn_pulse, grant, output req, req_led, lockout, press_cnt);
endinterface

// File: rtl/blink_div.sv
// blink_div: enable-gated toggle divider; restart forces the phase to a fresh "on" half-period
module blink_div #(
  parameter int BLINK_HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic blink
);
  localparam int PW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  logic [PW-1:0] ph_q, ph_d;
  logic          blink_q, blink_d;
  logic          wrap;
  assign wrap  = (ph_q == PW'(BLINK_HALF - 1));
  assign blink = blink_q;
  // advance the phase while enabled and flip the output at the end of each half-period
  always_comb begin
    ph_d    = restart ? '0 : en ? (wrap ? '0 : ph_q + 1'b1) : ph_q;
    blink_d = restart ? 1'b1 : (en && wrap) ? ~blink_q : blink_q;
  end
  // phase and blink registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q    <= '0;
      blink_q <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      blink_q <= blink_d;
    end
  end
endmodule

// File: rtl/ped_request_latch.sv
// ped_request_latch: holds a pedestrian request until granted, then locks out presses for a fixed interval
module ped_request_latch
  import tlc_pkg::*;
#(
  parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF,
  parameter int BLINK_HALF  = 4,
  parameter int CNT_W       = 8
) (
  input logic                clk,
  input logic                rst_n,
  ped_request_latch_if.slave bus
);
  localparam int LW = lock_w(LOCKOUT_CYC);
  state_t           state_q, state_d;
  logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             blink;
  logic             enter_pending;
  // next state, lockout countdown and saturating press count
  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    press_cnt_d = press_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.btn_pulse) begin
          state_d     = PENDING;
          press_cnt_d = (&press_cnt_q) ? press_cnt_q : press_cnt_q + 1'b1;
        end
      end
      PENDING: begin
        if (bus.grant) begin
          state_d    = LOCK;
          lock_cnt_d = LW'(LOCKOUT_CYC - 1);
        end
      end
      LOCK: begin
        state_d    = (lock_cnt_q == '0) ? IDLE : LOCK;
        lock_cnt_d = (lock_cnt_q == '0) ? lock_cnt_q : lock_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, lockout counter and press counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_cnt_q  <= '0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      press_cnt_q <= press_cnt_d;
    end
  end
  assign enter_pending = (state_d == PENDING) && (state_q != PENDING);
  blink_div #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q == PENDING),
    .restart (enter_pending),
    .blink   (blink)
  );
  assign bus.req       = (state_q == PENDING);
  assign bus.lockout   = (state_q == LOCK);
  assign bus.req_led   = blink & bus.req;
  assign bus.press_cnt = press_cnt_q;
endmodule

// File: tb/tb_ped_request_latch.sv
// tb_ped_request_latch: directed and random stimulus checked against a cycle-indexed request model
module tb_ped_request_latch;
  localparam int L  = 16;
  localparam int BH = 4;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  int cyc, lock_end, pend_start, count;
  bit pending;
  logic [19:0] led_seen;
  logic [19:0] led_want;
  ped_request_latch_if #(.CNT_W(CW)) bus ();
  ped_request_latch #(.LOCKOUT_CYC(L), .BLINK_HALF(BH), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    cyc = 0;
    lock_end = -1;
    pend_start = 0;
    count = 0;
    pending = 0;
  endtask
  task automatic chk_all();
    chk("req", {31'd0, bus.req}, {31'd0, pending});
    chk("lockout", {31'd0, bus.lockout}, (cyc <= lock_end) ? 32'd1 : 32'd0);
    chk("req_led", {31'd0, bus.req_led}, (pending && (((cyc - pend_start) / BH) % 2 == 0)) ? 32'd1 : 32'd0);
    chk("press_cnt", {30'd0, bus.press_cnt}, (count > 3) ? 32'd3 : 32'(count));
  endtask
  task automatic step(input logic b, input logic g);
    @(negedge clk);
    bus.btn_pulse = b;
    bus.grant = g;
    @(posedge clk);
    if (pending) begin
      if (g) begin
        pending = 0;
        lock_end = cyc + L;
      end
    end else if (cyc > lock_end && b) begin
      pending = 1;
      pend_start = cyc + 1;
      count++;
    end
    cyc++;
    #1;
    chk_all();
  endtask
  initial begin
    bus.btn_pulse = 1'b0;
    bus.grant = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("press_req", {31'd0, bus.req}, 32'd1);
    chk("press_cnt1", {30'd0, bus.press_cnt}, 32'd1);
    led_seen[19] = bus.req_led;
    for (int i = 1; i < 20; i++) begin
      step(1'b0, 1'b0);
      led_seen[19 - i] = bus.req_led;
    end
    led_want = 20'b1111_0000_1111_0000_1111;
    chk("blink_pattern", {12'd0, led_seen}, {12'd0, led_want});
    step(1'b0, 1'b1);
    chk("grant_led", {31'd0, bus.req_led}, 32'd0);
    chk("grant_lockout", {31'd0, bus.lockout}, 32'd1);
    repeat (L - 1) step(1'b0, 1'b0);
    chk("lock_last", {31'd0, bus.lockout}, 32'd1);
    step(1'b1, 1'b0);
    chk("drop_req", {31'd0, bus.req}, 32'd0);
    chk("drop_cnt", {30'd0, bus.press_cnt}, 32'd1);
    step(1'b1, 1'b0);
    chk("accept_req", {31'd0, bus.req}, 32'd1);
    chk("accept_cnt", {30'd0, bus.press_cnt}, 32'd2);
    step(1'b1, 1'b0);
    chk("merge_cnt", {30'd0, bus.press_cnt}, 32'd2);
    step(1'b0, 1'b1);
    repeat (L) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("sim_idle_req", {31'd0, bus.req}, 32'd1);
    chk("sim_idle_cnt", {30'd0, bus.press_cnt}, 32'd3);
    step(1'b1, 1'b1);
    chk("sim_pend_lock", {31'd0, bus.lockout}, 32'd1);
    chk("sim_pend_cnt", {30'd0, bus.press_cnt}, 32'd3);
    repeat (L) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("sat_req", {31'd0, bus.req}, 32'd1);
    chk("sat_cnt", {30'd0, bus.press_cnt}, 32'd3);
    step(1'b0, 1'b1);
    repeat (L) step(1'b0, 1'b0);
    repeat (400) step(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 9) == 0));
    repeat (L + 1) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    chk("mid_lock", {31'd0, bus.lockout}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("post_rst_req", {31'd0, bus.req}, 32'd1);
    chk("post_rst_cnt", {30'd0, bus.press_cnt}, 32'd1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
